uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
// - Parametrised UART receiver; next generation of the peripheral-bus UART receive path.
// - Samples rx with the shared baud-rate oversampling tick and assembles 5..9 data bits.
// - Adds optional parity, 1/2 stop bits, false-start rejection and break detect.
// - Frames are delivered through a valid/ready holding register with error flags and overrun reporting.
// - Feeds the UART RX FIFO / accumulator-mux read path.
// PARAMETERS
// DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
// OVERSAMPLE  16  s_tick pulses per bit period, even, >= 8
// STOP_BITS   1   number of stop bits, legal 1 or 2
// PARITY_EN   0   1 = one parity bit follows the data bits
// PARITY_ODD  0   1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
// PORTS
// clk         in   1          system clock
// reset       in   1          synchronous, active-high reset
// s_tick      in   1          oversampling enable, one clk wide, OVERSAMPLE pulses per bit
// rx          in   1          serial input, asynchronous, idle high
// rx_data     out  DATA_BITS  received data word, valid while rx_valid=1
// rx_valid    out  1          holding register contains an unread frame
// rx_ready    in   1          consumer accepts rx_data on this clk when rx_valid=1
// parity_err  out  1          parity mismatch for the frame in rx_data
// frame_err   out  1          a stop bit was sampled low for the frame in rx_data
// overrun     out  1          one-clk pulse: a frame completed while the holding register was full
// break_det   out  1          one-clk pulse: break condition detected
// busy        out  1          1 in any state other than IDLE
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-high, on clk and reset.
// - Reset values: all outputs 0, state IDLE, counters 0.
// - Reset mid-frame aborts the frame and delivers nothing.
// - rx passes through a 2-flop synchronizer (reset value 1). All FSM decisions use the synced rx, rxs.
// - Tick counter width is $clog2(OVERSAMPLE). The counter advances only on s_tick=1.
// - States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
// - IDLE: rxs=0 -> START, cnt=0.
// - START: on the tick where cnt==OVERSAMPLE/2-1, sample rxs.
//   - rxs=1 -> IDLE (false start; no flags raised).
//   - rxs=0 -> DATA, cnt=0, n=0.
// - DATA: on the tick where cnt==OVERSAMPLE-1, shift rxs into the MSB of the shift register and set cnt=0.
//   - After DATA_BITS samples go to PARITY if PARITY_EN=1, else to STOP.
// - PARITY: sample at cnt==OVERSAMPLE-1.
//   - Even parity: perr = ^{data,p}. Odd parity: perr = ~^{data,p}.
// - STOP: sample at cnt==OVERSAMPLE-1, STOP_BITS times.
//   - ferr is set if any stop sample is 0.
//   - After the last stop sample the frame completes.
//   - ferr=0 -> IDLE. ferr=1 -> WAIT_IDLE.
// - WAIT_IDLE: stay until rxs=1, then IDLE. This prevents a held-low line from re-triggering.
// - Frame completion (one clk): load rx_data, parity_err and frame_err, then set rx_valid.
//   - rx_valid rises the clk after the s_tick that sampled the last stop bit.
// - Handshake: rx_valid stays high until rx_valid & rx_ready, then it clears next clk.
//   - rx_data and flags are stable while rx_valid=1.
// - Completion while rx_valid=1 and rx_ready=0: the held frame is kept, the new frame is dropped, overrun pulses.
// - Completion in the same clk as rx_valid & rx_ready: the new frame loads, rx_valid stays 1, no overrun.
// - Break: all data bits 0, parity sample 0 (if present) and every stop sample 0.
//   - break_det pulses at completion. The frame is still delivered (data 0, frame_err=1).
// - s_tick asserted in IDLE or WAIT_IDLE has no effect. Missing ticks stall the FSM and are not an error.
// STRUCTURE
// - uart_pkg: the state enum type and the PARITY_EVEN / PARITY_ODD constants, shared with the future uart_tx_frame.
// - Sub-module uart_rx_sync: 2-flop synchronizer, reset to 1. Everything else stays in one module.
// TESTING
// - 8N1, send 0x55 with rx_ready=1 -> rx_data=0x55, rx_valid for 1 clk, no flags.
// - PARITY_EN=1 even, send 0xA3 with parity bit 1 -> parity_err=1, rx_data=0xA3.
// - rx low for 4 ticks only (OVERSAMPLE=16) -> returns to IDLE, rx_valid stays 0, busy drops.
// - Send 0x3C with stop bit 0 -> frame_err=1. FSM stays in WAIT_IDLE until rx=1.
// - rx held low for 20 bit times -> exactly one frame (0x00, frame_err=1) and one break_det pulse; nothing more until rx high.
// - rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once.
// - Assert reset mid-DATA -> outputs 0, IDLE, no frame; the next 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive path (and the transmit path
// that will follow it).
//   uart_state_e  : frame FSM state encoding
//   PARITY_EVEN   : parity sense value for even parity
//   PARITY_ODD    : parity sense value for odd parity
//   parity_of     : XOR-reduce helper over a data word
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int MAX_DATA_BITS = 9;

    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial input. Resets to 1 so
// the receiver sees an idle line while reset is applied.
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   d      in  asynchronous input
//   q      out synchronized output
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
// Parametrised UART receiver. Oversamples rx with the shared s_tick enable,
// assembles DATA_BITS data bits LSB first, optionally checks parity, checks
// STOP_BITS stop bits, rejects false starts and detects break. Completed
// frames are held in a valid/ready register with their error flags.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   s_tick      in   oversampling enable, OVERSAMPLE pulses per bit
//   rx          in   asynchronous serial input, idle high
//   rx_data     out  received data word (valid while rx_valid=1)
//   rx_valid    out  holding register contains an unread frame
//   rx_ready    in   consumer accepts rx_data when rx_valid=1
//   parity_err  out  parity mismatch for the held frame
//   frame_err   out  a stop bit was sampled low for the held frame
//   overrun     out  one-clk pulse, frame dropped because the holder was full
//   break_det   out  one-clk pulse, break condition detected
//   busy        out  FSM not in IDLE
//
// State table
//   state        | meaning
//   ST_IDLE      | line idle, waiting for a falling edge
//   ST_START     | qualifying the start bit at its mid point
//   ST_DATA      | sampling DATA_BITS data bits
//   ST_PARITY    | sampling the parity bit
//   ST_STOP      | sampling STOP_BITS stop bits, frame completes on the last
//   ST_WAIT_IDLE | framing error seen, waiting for the line to return high
// ----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = 4;

    localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    // Parity error is the XOR of data and parity bit, inverted for odd parity.
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                   : uart_pkg::PARITY_EVEN;

    logic rxs;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;
    logic                 frame_done;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
            break_q    <= break_d;
        end
    end

    // Frame FSM. zero_q tracks whether every sample since the start bit was 0,
    // which is the break condition once the last stop bit is in.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (cnt_q == CNT_HALF) begin
                        if (rxs) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            n_d     = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            zero_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        zero_d  = zero_q & ~rxs;
                        if (n_q == DATA_LAST) begin
                            n_d     = '0;
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        n_d     = '0;
                        perr_d  = parity_of(MAX_DATA_BITS'(shift_q)) ^ rxs ^ PAR_SENSE;
                        zero_d  = zero_q & ~rxs;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~rxs;
                        zero_d = zero_q & ~rxs;
                        if (n_q == STOP_LAST) begin
                            n_d        = '0;
                            frame_done = 1'b1;
                            state_d    = ferr_d ? ST_WAIT_IDLE : ST_IDLE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                // A line held low must not look like a fresh start bit.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                n_d     = '0;
            end
        endcase
    end

    // Holding register. A completion in the same clk as an accept refills
    // the register; a completion against an unaccepted frame is dropped.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        break_d    = 1'b0;

        if (frame_done) begin
            break_d = zero_d;
            if (valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_d;
                valid_d    = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame. Instance A is 8N1, instance B is 8E1.
// s_tick pulses once every 4 clks, so one bit lasts 64 clks.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int TDIV = 4;
    localparam int BIT  = 16 * TDIV;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic [1:0] tdiv = 2'd0;

    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rx_ready_a = 1'b1, rx_ready_b = 1'b1;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       parity_err_a, parity_err_b;
    logic       frame_err_a, frame_err_b;
    logic       overrun_a, overrun_b;
    logic       break_det_a, break_det_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int frames_a = 0, frames_b = 0;
    int ovr_a = 0, brk_a = 0, brk_b = 0, ovr_b = 0;
    int valid_clks_a = 0;
    int f0, o0, b0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    uart_rx_frame #(
        .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a),
        .break_det(break_det_a), .busy(busy_a)
    );

    uart_rx_frame #(
        .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b),
        .break_det(break_det_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv   <= tdiv + 2'd1;
        s_tick <= (tdiv == 2'd3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop and compare on every accepted frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid_a) valid_clks_a++;
            if (overrun_a) ovr_a++;
            if (break_det_a) brk_a++;
            if (overrun_b) ovr_b++;
            if (break_det_b) brk_b++;
            if (rx_valid_a && rx_ready_a) begin
                frames_a++;
                chk("a_frame_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    ea = q_a.pop_front();
                    chk("a_rx_data", 32'(rx_data_a), 32'(ea.d));
                    chk("a_parity_err", 32'(parity_err_a), 32'(ea.pe));
                    chk("a_frame_err", 32'(frame_err_a), 32'(ea.fe));
                end
            end
            if (rx_valid_b && rx_ready_b) begin
                frames_b++;
                chk("b_frame_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    eb = q_b.pop_front();
                    chk("b_rx_data", 32'(rx_data_b), 32'(eb.d));
                    chk("b_parity_err", 32'(parity_err_b), 32'(eb.pe));
                    chk("b_frame_err", 32'(frame_err_b), 32'(eb.fe));
                end
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // Start bit, nb bits LSB first, one stop bit; a high stop bit is followed
    // by one idle bit, a low one leaves the line low.
    task automatic send_frame(input bit sel, input logic [8:0] bits, input int nb,
                              input logic stop_v);
        drive(sel, 1'b0);
        clk_wait(BIT);
        for (int i = 0; i < nb; i++) begin
            drive(sel, bits[i]);
            clk_wait(BIT);
        end
        drive(sel, stop_v);
        clk_wait(BIT);
        if (stop_v) begin
            drive(sel, 1'b1);
            clk_wait(BIT);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d; e.pe = ^{d, p}; e.fe = 1'b0;
        q_b.push_back(e);
    endtask

    initial begin
        clk_wait(4);
        reset = 1'b0;
        clk_wait(4);

        // reset state
        chk("rst_valid", 32'(rx_valid_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_data", 32'(rx_data_a), 32'd0);
        chk("rst_perr", 32'(parity_err_a), 32'd0);
        chk("rst_ferr", 32'(frame_err_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);

        // 8N1 0x55
        valid_clks_a = 0;
        f0 = frames_a;
        push_a(8'h55, 1'b0, 1'b0);
        send_frame(1'b0, 9'h055, 8, 1'b1);
        chk("n81_delivered", 32'(frames_a - f0), 32'd1);
        chk("n81_valid_clks", 32'(valid_clks_a), 32'd1);
        chk("n81_queue_empty", 32'(q_a.size()), 32'd0);

        // 8E1: bad parity on 0xA3, then good parity on 0x5A
        push_b(8'hA3, 1'b1);
        send_frame(1'b1, {1'b1, 8'hA3}, 9, 1'b1);
        push_b(8'h5A, 1'b0);
        send_frame(1'b1, {1'b0, 8'h5A}, 9, 1'b1);
        chk("par_frames", 32'(frames_b), 32'd2);
        chk("par_queue_empty", 32'(q_b.size()), 32'd0);
        chk("par_no_break", 32'(brk_b), 32'd0);

        // false start: 4 ticks low
        f0 = frames_a;
        rx_a = 1'b0;
        clk_wait(4 * TDIV);
        chk("fs_busy_high", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        clk_wait(BIT);
        chk("fs_busy_low", 32'(busy_a), 32'd0);
        chk("fs_no_valid", 32'(rx_valid_a), 32'd0);
        chk("fs_no_frame", 32'(frames_a - f0), 32'd0);

        // 0x3C with low stop bit, line stays low
        b0 = brk_a;
        push_a(8'h3C, 1'b0, 1'b1);
        send_frame(1'b0, 9'h03C, 8, 1'b0);
        clk_wait(2 * BIT);
        chk("fe_wait_idle_busy", 32'(busy_a), 32'd1);
        chk("fe_queue_empty", 32'(q_a.size()), 32'd0);
        chk("fe_no_break", 32'(brk_a - b0), 32'd0);
        rx_a = 1'b1;
        clk_wait(6);
        chk("fe_idle_after_high", 32'(busy_a), 32'd0);
        clk_wait(BIT);

        // break: 20 bit times low
        f0 = frames_a;
        b0 = brk_a;
        push_a(8'h00, 1'b0, 1'b1);
        rx_a = 1'b0;
        clk_wait(20 * BIT);
        chk("brk_one_frame", 32'(frames_a - f0), 32'd1);
        chk("brk_one_pulse", 32'(brk_a - b0), 32'd1);
        chk("brk_busy", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        clk_wait(BIT);
        chk("brk_idle", 32'(busy_a), 32'd0);
        chk("brk_nothing_more", 32'(frames_a - f0), 32'd1);

        // overrun: hold 0x11, drop 0x22
        rx_ready_a = 1'b0;
        o0 = ovr_a;
        f0 = frames_a;
        push_a(8'h11, 1'b0, 1'b0);
        send_frame(1'b0, 9'h011, 8, 1'b1);
        send_frame(1'b0, 9'h022, 8, 1'b1);
        chk("ovr_data_held", 32'(rx_data_a), 32'h11);
        chk("ovr_valid_held", 32'(rx_valid_a), 32'd1);
        chk("ovr_pulses", 32'(ovr_a - o0), 32'd1);
        rx_ready_a = 1'b1;
        clk_wait(4);
        chk("ovr_one_frame", 32'(frames_a - f0), 32'd1);
        chk("ovr_queue_empty", 32'(q_a.size()), 32'd0);

        // reset in the middle of the data bits
        f0 = frames_a;
        rx_a = 1'b0;
        clk_wait(BIT);
        rx_a = 1'b0;
        clk_wait(BIT);
        rx_a = 1'b1;
        clk_wait(2 * BIT);
        reset = 1'b1;
        clk_wait(2);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_valid", 32'(rx_valid_a), 32'd0);
        chk("mid_rst_data", 32'(rx_data_a), 32'd0);
        reset = 1'b0;
        clk_wait(2 * BIT);
        chk("mid_rst_no_frame", 32'(frames_a - f0), 32'd0);
        push_a(8'h7E, 1'b0, 1'b0);
        send_frame(1'b0, 9'h07E, 8, 1'b1);
        chk("post_rst_frame", 32'(frames_a - f0), 32'd1);
        chk("post_rst_queue_empty", 32'(q_a.size()), 32'd0);
        chk("no_overrun_b", 32'(ovr_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
